mem_access_unit: RTL and testbench
==================================

# mem_access_unit

Initiator side of the data-memory port. It sits in the MEM stage between the pipeline's load/store request and the byte-enabled, word-organised data memory. It converts a byte address, size and signedness into a word address, byte enables and lane-shifted write data. It splits misaligned accesses into two consecutive word accesses, stalling the pipeline for one cycle, and it assembles and sign- or zero-extends load results.

## Interface
- No parameters. Memory geometry is fixed: 256 words × 32 bits, 10-bit byte address.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `req_valid` in 1: a load/store request is present this cycle.
- `req_write` in 1: 1 = store, 0 = load.
- `req_size` in 2: `mem_size_t` (byte / half / word).
- `req_unsigned` in 1: zero-extend loads (LBU/LHU) when 1.
- `req_addr` in 32: byte address. Only [9:0] is used; [31:10] is ignored.
- `req_wdata` in 32: store data, right-aligned.
- `stall` out 1: hold the pipeline. The request inputs must stay stable while this is high.
- `load_valid` out 1: `load_data` is valid this cycle.
- `load_data` out 32: extended load result.
- `mem_byte_address` out 10: the low 2 bits are always 00.
- `mem_write_enable` out 1.
- `mem_read_enable` out 1.
- `mem_byte_enable` out 4.
- `mem_write_data` out 32: lane-shifted.
- `mem_read_data` in 32: combinational read from memory. Disabled lanes read as zero.

## Operation
- Let `o = req_addr[1:0]` and `w = req_addr[9:2]`.
- An access is misaligned when it is a half with o=3, or a word with o≠0. Bytes are never misaligned.
- FSM state `IDLE`, aligned request:
  - Drive `mem_byte_address = {w,2'b00}`.
  - Byte enables: byte `4'b0001<<o`; half `4'b0011<<o`; word `4'b1111`.
  - Write data: `req_wdata << 8*o`.
  - `mem_write_enable = req_write`, `mem_read_enable = !req_write`.
  - `stall = 0`. For a load, `load_valid = 1` in the same cycle.
  - Load: `(mem_read_data >> 8*o)`, then extended to the requested size.
- FSM state `IDLE`, misaligned request (phase 1):
  - Access word `w`.
  - Enables: half o=3 → `1000`; word o=1/2/3 → `1110` / `1100` / `1000`.
  - Write data: `req_wdata << 8*o`.
  - `stall = 1`, `load_valid = 0`.
  - Latch addr, size, unsigned, write and wdata.
  - Latch `part_lo = mem_read_data >> 8*o`.
  - Next state: `SECOND`.
- FSM state `SECOND` (phase 2):
  - Access word `w+1` mod 256, so word 255 wraps to 0.
  - Enables: half → `0001`; word o=1/2/3 → `0001` / `0011` / `0111`.
  - Write data: `wdata >> 8*(4-o)`.
  - Load result: `part_lo | (mem_read_data << 8*(4-o))`, then extended.
  - `stall = 0`, `load_valid = 1` for loads.
  - All request inputs are ignored in this state.
  - Next state: `IDLE`.
- Extension rules:
  - Byte: bits [7:0], with bit 7 replicated unless `req_unsigned`.
  - Half: bits [15:0], with bit 15 replicated unless `req_unsigned`.
  - Word: passed through unchanged.
- When `req_valid = 0` in `IDLE`, all memory enables and byte enables are 0.

## Timing
- Memory side:
  - Reads are combinational within the cycle.
  - Writes commit at the `clk` edge ending the cycle in which `mem_write_enable` is high.
- Latency:
  - Aligned: 0 cycles (result in the request cycle).
  - Misaligned: 1 extra cycle.
  - A misaligned store writes both halves on consecutive edges.
- Reset values: state `IDLE`, latches 0. While `reset` is high, `stall`, `load_valid`, `mem_write_enable`, `mem_read_enable` and `mem_byte_enable` are all 0, and `mem_byte_address`, `mem_write_data` and `load_data` are 0.
- Reset during `SECOND`: the FSM returns to `IDLE` and phase 2 is not issued. A misaligned store is left half-written; this is accepted behaviour.
- A back-to-back request in the cycle after `SECOND` is accepted normally.

## Structure
- `common` package: `typedef enum logic [1:0] {SIZE_BYTE=2'b00, SIZE_HALF=2'b01, SIZE_WORD=2'b10} mem_size_t`.
- State enum `mau_state_t {MAU_IDLE, MAU_SECOND}` is local to the module.
- One combinational sub-module, `load_extend` (inputs: raw 32-bit value, size, unsigned; output: 32-bit value), instantiated once on the load result path.

## Test plan
- Store word 0xDEADBEEF @0x008, then load word @0x008:
  - Store: one cycle, `mem_byte_enable = 1111`.
  - Load: `load_data = 0xDEADBEEF` in the same cycle, `stall = 0`.
- Store byte 0x80 @0x00D, then load:
  - Store: `mem_byte_enable = 0010`, `mem_write_data = 0x00008000`.
  - LB returns 0xFFFFFF80; LBU returns 0x00000080.
- Store word 0x11223344 @0x00B (misaligned):
  - Cycle 1: address 0x008, enables `1000`, data 0x44000000, `stall = 1`.
  - Cycle 2: address 0x00C, enables `0111`, data 0x00112233.
  - A subsequent load word @0x00B returns 0x11223344 after a 1-cycle stall.
- Load half @0x3FF with memory word 255 = 0xAB000000 and word 0 = 0x000000CD:
  - Phase 2 address is 0x000 (wrap-around).
  - LH returns 0xFFFFCDAB.
- Reset asserted during `SECOND` of a misaligned store @0x005:
  - Only the phase-1 bytes are written.
  - All enables are 0 during reset.
  - FSM is in `IDLE` afterwards, and the next aligned request completes with no stall.
- Idle cycles with `req_valid = 0` and random other inputs: `mem_write_enable = mem_read_enable = 0`, `mem_byte_enable = 0000`, `load_valid = 0`.

Source files
------------

// File: rtl/common_pkg.sv
// Shared definitions for the data-memory access path: access size encoding
// and small helpers that describe lane usage for a given size and offset.
package common;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'b00,
        SIZE_HALF = 2'b01,
        SIZE_WORD = 2'b10
    } mem_size_t;

    // Byte-lane mask of an access that starts at lane 0.
    function automatic logic [3:0] size_base_be(input mem_size_t size);
        case (size)
            SIZE_BYTE: return 4'b0001;
            SIZE_HALF: return 4'b0011;
            SIZE_WORD: return 4'b1111;
            default:   return 4'b0000;
        endcase
    endfunction

    // True when the access crosses a word boundary and needs two memory cycles.
    function automatic logic is_misaligned(input mem_size_t size, input logic [1:0] offset);
        case (size)
            SIZE_HALF: return offset == 2'd3;
            SIZE_WORD: return offset != 2'd0;
            default:   return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_unit_load_extend.sv
// Sign- or zero-extension of a right-aligned load value to 32 bits.
module load_extend
    import common::*;
(
    input  logic [31:0] raw,
    input  mem_size_t   size,
    input  logic        is_unsigned,
    output logic [31:0] value
);

    // Pick the low byte/half and replicate its top bit unless unsigned.
    always_comb begin
        case (size)
            SIZE_BYTE: value = {{24{raw[7] & ~is_unsigned}}, raw[7:0]};
            SIZE_HALF: value = {{16{raw[15] & ~is_unsigned}}, raw[15:0]};
            default:   value = raw;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage initiator for the word-organised data memory. Aligned accesses
// complete in the request cycle; accesses crossing a word boundary are split
// into two consecutive word accesses with a one-cycle pipeline stall.
module mem_access_unit
    import common::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_write,
    input  mem_size_t   req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        stall,
    output logic        load_valid,
    output logic [31:0] load_data,
    output logic [9:0]  mem_byte_address,
    output logic        mem_write_enable,
    output logic        mem_read_enable,
    output logic [3:0]  mem_byte_enable,
    output logic [31:0] mem_write_data,
    input  logic [31:0] mem_read_data,
    output logic        dbg_state
);

    typedef enum logic {
        MAU_IDLE   = 1'b0,
        MAU_SECOND = 1'b1
    } mau_state_t;

    mau_state_t state, next_state;

    // Request fields held across the second phase of a split access.
    logic [1:0]  lat_o;
    logic [7:0]  lat_w;
    mem_size_t   lat_size;
    logic        lat_unsigned;
    logic        lat_write;
    logic [31:0] lat_wdata;
    logic [31:0] lat_part_lo;

    logic        latch_en;
    logic [31:0] raw_load;
    mem_size_t   ext_size;
    logic        ext_unsigned;

    logic [1:0]  req_o;
    logic [7:0]  req_w;
    logic [4:0]  lo_shift;
    logic [2:0]  hi_lanes;
    logic [5:0]  hi_shift;
    logic        unused_addr_bits;

    assign req_o    = req_addr[1:0];
    assign req_w    = req_addr[9:2];
    assign lo_shift = {req_o, 3'b000};
    // Second-phase data sits (4 - offset) lanes away from the first phase.
    assign hi_lanes = 3'd4 - {1'b0, lat_o};
    assign hi_shift = {hi_lanes, 3'b000};
    assign unused_addr_bits = ^req_addr[31:10];
    assign dbg_state = (state == MAU_SECOND);

    // Memory drive, stall and load assembly for the current phase.
    always_comb begin
        next_state       = state;
        stall            = 1'b0;
        load_valid       = 1'b0;
        mem_byte_address = '0;
        mem_write_enable = 1'b0;
        mem_read_enable  = 1'b0;
        mem_byte_enable  = '0;
        mem_write_data   = '0;
        raw_load         = '0;
        ext_size         = req_size;
        ext_unsigned     = req_unsigned;
        latch_en         = 1'b0;
        if (!reset) begin
            case (state)
                MAU_IDLE: begin
                    if (req_valid) begin
                        mem_byte_address = {req_w, 2'b00};
                        mem_byte_enable  = size_base_be(req_size) << req_o;
                        mem_write_data   = req_wdata << lo_shift;
                        mem_write_enable = req_write;
                        mem_read_enable  = !req_write;
                        if (is_misaligned(req_size, req_o)) begin
                            stall      = 1'b1;
                            latch_en   = 1'b1;
                            next_state = MAU_SECOND;
                        end else begin
                            load_valid = !req_write;
                            raw_load   = mem_read_data >> lo_shift;
                        end
                    end
                end
                MAU_SECOND: begin
                    mem_byte_address = {lat_w + 8'd1, 2'b00};
                    mem_byte_enable  = size_base_be(lat_size) >> hi_lanes;
                    mem_write_data   = lat_wdata >> hi_shift;
                    mem_write_enable = lat_write;
                    mem_read_enable  = !lat_write;
                    load_valid       = !lat_write;
                    raw_load         = lat_part_lo | (mem_read_data << hi_shift);
                    ext_size         = lat_size;
                    ext_unsigned     = lat_unsigned;
                    next_state       = MAU_IDLE;
                end
                default: next_state = MAU_IDLE;
            endcase
        end
    end

    // State register and capture of the first phase of a split access.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= MAU_IDLE;
            lat_o        <= '0;
            lat_w        <= '0;
            lat_size     <= SIZE_BYTE;
            lat_unsigned <= 1'b0;
            lat_write    <= 1'b0;
            lat_wdata    <= '0;
            lat_part_lo  <= '0;
        end else begin
            state <= next_state;
            if (latch_en) begin
                lat_o        <= req_o;
                lat_w        <= req_w;
                lat_size     <= req_size;
                lat_unsigned <= req_unsigned;
                lat_write    <= req_write;
                lat_wdata    <= req_wdata;
                lat_part_lo  <= mem_read_data >> lo_shift;
            end
        end
    end

    load_extend u_load_extend (
        .raw         (raw_load),
        .size        (ext_size),
        .is_unsigned (ext_unsigned),
        .value       (load_data)
    );

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: byte-array reference memory, word memory model
// on the DUT port, directed boundary cases, then randomized traffic.
`timescale 1ns/1ps
module tb_mem_access_unit;
    import common::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_write, req_unsigned;
    mem_size_t   req_size;
    logic [31:0] req_addr, req_wdata;
    logic        stall, load_valid;
    logic [31:0] load_data;
    logic [9:0]  mem_byte_address;
    logic        mem_write_enable, mem_read_enable;
    logic [3:0]  mem_byte_enable;
    logic [31:0] mem_write_data, mem_read_data;
    logic        dbg_state;

    int errors = 0;
    int checks = 0;
    logic [31:0] exp_q[$];
    logic [31:0] last_load = '0;
    logic [31:0] mem[256];
    logic [7:0]  ref_mem[1024];
    logic [9:0]  cap_addr[2];
    logic [3:0]  cap_be[2];
    logic [31:0] cap_wd[2];

    mem_access_unit dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_write(req_write),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .stall(stall), .load_valid(load_valid),
        .load_data(load_data), .mem_byte_address(mem_byte_address),
        .mem_write_enable(mem_write_enable), .mem_read_enable(mem_read_enable),
        .mem_byte_enable(mem_byte_enable), .mem_write_data(mem_write_data),
        .mem_read_data(mem_read_data), .dbg_state(dbg_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- memory on the DUT port ----------------
    always_comb begin
        mem_read_data = '0;
        if (mem_read_enable)
            for (int i = 0; i < 4; i++)
                if (mem_byte_enable[i])
                    mem_read_data[8*i +: 8] = mem[mem_byte_address[9:2]][8*i +: 8];
    end

    initial forever begin
        @(posedge clk);
        if (mem_write_enable)
            for (int i = 0; i < 4; i++)
                if (mem_byte_enable[i])
                    mem[mem_byte_address[9:2]][8*i +: 8] = mem_write_data[8*i +: 8];
    end

    // ---------------- reference model (byte addressed) ----------------
    function automatic int nbytes(input mem_size_t sz);
        case (sz)
            SIZE_BYTE: return 1;
            SIZE_HALF: return 2;
            default:   return 4;
        endcase
    endfunction

    function automatic logic [31:0] ref_load(input mem_size_t sz, input logic uns, input logic [31:0] addr);
        logic [31:0] v;
        int n;
        n = nbytes(sz);
        v = '0;
        for (int k = 0; k < n; k++)
            v[8*k +: 8] = ref_mem[(int'(addr[9:0]) + k) % 1024];
        if (n == 1 && !uns && v[7])  v = v | 32'hFFFF_FF00;
        if (n == 2 && !uns && v[15]) v = v | 32'hFFFF_0000;
        return v;
    endfunction

    task automatic ref_store(input int n, input logic [31:0] addr, input logic [31:0] wd);
        for (int k = 0; k < n; k++)
            ref_mem[(int'(addr[9:0]) + k) % 1024] = wd[8*k +: 8];
    endtask

    task automatic backdoor_word(input int w, input logic [31:0] v);
        mem[w] = v;
        for (int k = 0; k < 4; k++) ref_mem[4*w + k] = v[8*k +: 8];
    endtask

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every presented load result is matched to the oldest expectation.
    initial forever begin
        @(negedge clk);
        if (load_valid === 1'b1) begin
            last_load = load_data;
            if (exp_q.size() == 0) check("unexpected_load", load_data, 32'hxxxx_xxxx);
            else check("load_data", load_data, exp_q.pop_front());
        end
    end

    // ---------------- driver ----------------
    // Called just after a rising edge; holds the request until it completes.
    task automatic issue(input logic wr, input mem_size_t sz, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wd);
        int n;
        int cycles;
        logic mis;
        n = nbytes(sz);
        mis = (int'(addr[1:0]) + n) > 4;
        cycles = mis ? 2 : 1;
        if (wr) ref_store(n, addr, wd);
        else exp_q.push_back(ref_load(sz, uns, addr));
        req_valid = 1'b1; req_write = wr; req_size = sz;
        req_unsigned = uns; req_addr = addr; req_wdata = wd;
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            cap_addr[c] = mem_byte_address;
            cap_be[c]   = mem_byte_enable;
            cap_wd[c]   = mem_write_data;
            check("stall", 32'(stall), 32'(mis && c == 0));
            @(posedge clk); #1;
        end
    endtask

    task automatic idle_cycle();
        req_valid = 1'b0; req_write = 1'($urandom); req_unsigned = 1'($urandom);
        req_size = mem_size_t'($urandom_range(0, 2)); req_addr = $urandom; req_wdata = $urandom;
        @(negedge clk);
        check("idle_en", {28'b0, mem_write_enable, mem_read_enable, load_valid, stall}, 32'h0);
        check("idle_be", 32'(mem_byte_enable), 32'h0);
        @(posedge clk); #1;
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        errors++;
        $display("FAIL timeout: test did not complete within the time limit");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // ---------------- main sequence ----------------
    initial begin
        for (int w = 0; w < 256; w++) backdoor_word(w, $urandom);
        reset = 1'b1; req_valid = 1'b1; req_write = 1'b1; req_size = SIZE_WORD;
        req_unsigned = 1'b0; req_addr = 32'h0000_0007; req_wdata = 32'hFFFF_FFFF;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_ctl", {28'b0, stall, load_valid, mem_write_enable, mem_read_enable}, 32'h0);
        check("rst_be", 32'(mem_byte_enable), 32'h0);
        check("rst_addr", 32'(mem_byte_address), 32'h0);
        check("rst_wdata", mem_write_data, 32'h0);
        check("rst_load", load_data, 32'h0);
        @(posedge clk); #1;
        reset = 1'b0; req_valid = 1'b0;
        @(negedge clk);
        check("rst_state", 32'(dbg_state), 32'h0);
        @(posedge clk); #1;

        // aligned word store and load
        issue(1'b1, SIZE_WORD, 1'b0, 32'h008, 32'hDEAD_BEEF);
        check("sw_be", 32'(cap_be[0]), 32'hF);
        issue(1'b0, SIZE_WORD, 1'b0, 32'h008, 32'h0);
        check("lw_val", last_load, 32'hDEAD_BEEF);

        // byte store and signed/unsigned byte loads
        issue(1'b1, SIZE_BYTE, 1'b0, 32'h00D, 32'h0000_0080);
        check("sb_be", 32'(cap_be[0]), 32'h2);
        check("sb_wd", cap_wd[0], 32'h0000_8000);
        issue(1'b0, SIZE_BYTE, 1'b0, 32'h00D, 32'h0);
        check("lb_val", last_load, 32'hFFFF_FF80);
        issue(1'b0, SIZE_BYTE, 1'b1, 32'h00D, 32'h0);
        check("lbu_val", last_load, 32'h0000_0080);

        // misaligned word store split over two words
        issue(1'b1, SIZE_WORD, 1'b0, 32'h00B, 32'h1122_3344);
        check("msw_addr0", 32'(cap_addr[0]), 32'h008);
        check("msw_be0", 32'(cap_be[0]), 32'h8);
        check("msw_wd0", cap_wd[0], 32'h4400_0000);
        check("msw_addr1", 32'(cap_addr[1]), 32'h00C);
        check("msw_be1", 32'(cap_be[1]), 32'h7);
        check("msw_wd1", cap_wd[1], 32'h0011_2233);
        issue(1'b0, SIZE_WORD, 1'b0, 32'h00B, 32'h0);
        check("mlw_val", last_load, 32'h1122_3344);

        // half load wrapping from word 255 to word 0
        backdoor_word(255, 32'hAB00_0000);
        backdoor_word(0, 32'h0000_00CD);
        issue(1'b0, SIZE_HALF, 1'b0, 32'h3FF, 32'h0);
        check("wrap_addr1", 32'(cap_addr[1]), 32'h000);
        check("wrap_lh", last_load, 32'hFFFF_CDAB);

        // reset during the second phase of a misaligned store at 0x005
        req_valid = 1'b1; req_write = 1'b1; req_size = SIZE_WORD; req_unsigned = 1'b0;
        req_addr = 32'h005; req_wdata = 32'hA1B2_C3D4;
        @(negedge clk);
        check("rs_stall", 32'(stall), 32'h1);
        @(posedge clk); #1;
        ref_store(3, 32'h005, 32'hA1B2_C3D4);
        reset = 1'b1;
        @(negedge clk);
        check("rs_ctl", {28'b0, stall, load_valid, mem_write_enable, mem_read_enable}, 32'h0);
        check("rs_be", 32'(mem_byte_enable), 32'h0);
        @(posedge clk); #1;
        reset = 1'b0; req_valid = 1'b0;
        @(negedge clk);
        check("rs_state", 32'(dbg_state), 32'h0);
        @(posedge clk); #1;
        issue(1'b0, SIZE_WORD, 1'b0, 32'h004, 32'h0);
        issue(1'b0, SIZE_WORD, 1'b0, 32'h008, 32'h0);

        // idle cycles with random request fields
        repeat (6) idle_cycle();

        // randomized traffic, back-to-back and with idle gaps
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 4) == 0) idle_cycle();
            else issue(1'($urandom), mem_size_t'($urandom_range(0, 2)), 1'($urandom),
                       $urandom, $urandom);
        end
        req_valid = 1'b0;
        repeat (2) @(posedge clk);
        check("exp_q_drained", 32'(exp_q.size()), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
